conv_layer_sequencer: RTL and testbench
=======================================

CONV_LAYER_SEQUENCER -- requirements
Module: conv_layer_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_WIDTH, 32, width of one conv result word
- H, 32, image height
- W, 32, image width
- F, 5, filter size
- Derived: OH = H-F+1, OW = W-F+1
- Derived widths, each minimum 1: RW = ceil(log2(OH)), CW = ceil(log2(OW)), AW = ceil(log2(OH*OW))
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge
- reset, in, 1, asynchronous active-high reset
- start, in, 1, begin one full layer pass
- abort, in, 1, cancel the pass in progress
- busy, out, 1, pass in progress
- done, out, 1, one-cycle pass-complete pulse
- cu_start, out, 1, one-cycle issue pulse to the shared conv unit
- cu_row, out, RW, window top row m
- cu_col, out, CW, window left column l
- cu_done, in, 1, conv unit result valid
- cu_result, in, DATA_WIDTH, conv unit result
- out_we, out, 1, output buffer write enable
- out_addr, out, AW, output buffer address
- out_data, out, DATA_WIDTH, output buffer write data

Function
REQ-003 The FSM SHALL have exactly five states: IDLE, ISSUE, WAIT, WRITE, FINISH.
REQ-004 IDLE: start=1 and abort=0 SHALL move to ISSUE with row=0, col=0.
REQ-005 ISSUE: cu_start=1 for exactly one cycle; cu_row/cu_col = current row/col; next state WAIT.
REQ-006 WAIT: cu_row/cu_col held stable; state held until cu_done=1. On cu_done=1, cu_result is latched into a result register and the next state is WRITE.
REQ-007 cu_done SHALL be ignored in every state except WAIT, including the ISSUE cycle itself.
REQ-008 WRITE: out_we=1 for one cycle; out_addr = row*OW+col; out_data = latched result.
REQ-009 After WRITE, if col<OW-1: col+1 and go to ISSUE. Else if row<OH-1: col=0, row+1, go to ISSUE. Else go to FINISH.
REQ-010 FINISH: done=1 for one cycle; next state IDLE.
REQ-011 busy SHALL be 1 in ISSUE, WAIT, WRITE and FINISH, and 0 in IDLE.
REQ-012 start SHALL be ignored while busy=1.
REQ-013 abort=1 in any non-IDLE state SHALL force IDLE on the next edge and clear row/col. No done pulse and no further out_we follow. abort overrides cu_done, as well as start in the same cycle.
REQ-014 If start and abort are both 1 in IDLE, the FSM SHALL stay in IDLE.
REQ-015 Per-position cost SHALL be 2+k cycles, where k≥1 is the number of WAIT cycles up to and including the cu_done cycle. Minimum pass length is 3*OH*OW+1 cycles from the ISSUE entry through FINISH.
REQ-016 Output writes SHALL occur in strictly ascending address order 0..OH*OW-1, each exactly once per completed pass.
REQ-017 out_addr SHALL be computed at AW bits without truncation for all legal row/col.
REQ-018 out_addr and out_data SHALL be 0 whenever out_we=0.

Reset
REQ-019 On reset assertion, independent of clk, the block SHALL go to IDLE and clear busy, done, cu_start, out_we, cu_row, cu_col, out_addr, out_data, the result register, and the row/col counters to 0.
REQ-020 Reset asserted mid-pass SHALL discard the pass. After release the block SHALL wait in IDLE for a new start.

Verification
REQ-021 The bench SHALL cover these scenarios, with H=W=4, F=3 (OH=OW=2) unless stated:
- Nominal: start pulse, cu_done returned 1 cycle after each cu_start, results 0x11,0x22,0x33,0x44. Required: writes (addr,data) = (0,0x11),(1,0x22),(2,0x33),(3,0x44); issued (row,col) = (0,0),(0,1),(1,0),(1,1); done 13 cycles after the ISSUE entry; busy low after done.
- Variable latency: cu_done delayed 5 cycles on position 2. Required: cu_row=1, cu_col=0 held stable throughout; pass length = 13+4 cycles.
- Spurious/early events: cu_done=1 during the ISSUE cycle, and in IDLE, is ignored; start pulsed during WAIT is ignored. Required: exactly 4 writes and 1 done.
- Abort: abort asserted in WAIT of position 1. Required: IDLE next cycle, busy=0, no done, only address 0 written; a later start restarts at (0,0).
- Reset: async reset asserted mid-WRITE between clock edges. Required: out_we, busy and cu_start are 0 immediately; the next pass from start is complete and correct.
- Default parameters (32,32,5): required 784 writes, last out_addr=783, row/col wrap at 27.

Source files
------------

// File: rtl/conv_layer_sequencer.sv
// Conv layer sequencer: walks every OHxOW window position through one shared
// conv unit (issue, wait for result, write) and pulses done after the last write.
module conv_layer_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int H          = 32,
  parameter int W          = 32,
  parameter int F          = 5,
  localparam int OH = H - F + 1,
  localparam int OW = W - F + 1,
  localparam int RW = (OH > 1) ? $clog2(OH) : 1,
  localparam int CW = (OW > 1) ? $clog2(OW) : 1,
  localparam int AW = (OH * OW > 1) ? $clog2(OH * OW) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  cu_start,
  output logic [RW-1:0]         cu_row,
  output logic [CW-1:0]         cu_col,
  input  logic                  cu_done,
  input  logic [DATA_WIDTH-1:0] cu_result,
  output logic                  out_we,
  output logic [AW-1:0]         out_addr,
  output logic [DATA_WIDTH-1:0] out_data
);

  // state  | meaning
  // IDLE   | waiting for start
  // ISSUE  | one-cycle cu_start for (row, col)
  // WAIT   | holding (row, col) until cu_done
  // WRITE  | writing latched result to row*OW+col
  // FINISH | one-cycle done pulse
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, FINISH} state_t;

  localparam logic [RW-1:0] ROW_LAST = RW'(OH - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(OW - 1);

  state_t                  state_q, state_d;
  logic [RW-1:0]           row_q, row_d;
  logic [CW-1:0]           col_q, col_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic [AW-1:0]           addr_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      row_q    <= '0;
      col_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = ISSUE;
          row_d   = '0;
          col_d   = '0;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (cu_done) begin
          result_d = cu_result;
          state_d  = WRITE;
        end
      end
      WRITE: begin
        if (col_q < COL_LAST) begin
          col_d   = col_q + CW'(1);
          state_d = ISSUE;
        end else if (row_q < ROW_LAST) begin
          col_d   = '0;
          row_d   = row_q + RW'(1);
          state_d = ISSUE;
        end else begin
          state_d = FINISH;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // abort wins over cu_done and start; the result register is left alone
    if (abort && state_q != IDLE) begin
      state_d  = IDLE;
      row_d    = '0;
      col_d    = '0;
      result_d = result_q;
    end
  end

  assign addr_full = AW'(row_q) * AW'(OW) + AW'(col_q);

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FINISH);
  assign cu_start = (state_q == ISSUE);
  assign cu_row   = row_q;
  assign cu_col   = col_q;
  assign out_we   = (state_q == WRITE);
  assign out_addr = out_we ? addr_full : '0;
  assign out_data = out_we ? result_q : '0;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Bench for conv_layer_sequencer: a 4x4/F=3 instance for directed and random
// passes, plus a default-parameter instance for the full 28x28 walk.
module tb_conv_layer_sequencer;
  localparam int DW  = 32;
  localparam int S_OW = 2;
  localparam int S_N  = 4;
  localparam int D_OW = 28;
  localparam int D_N  = 784;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // small instance
  logic          s_start, s_abort, s_busy, s_done, s_cu_start, s_cu_done, s_out_we;
  logic [0:0]    s_cu_row, s_cu_col;
  logic [1:0]    s_out_addr;
  logic [DW-1:0] s_cu_result, s_out_data;

  conv_layer_sequencer #(.DATA_WIDTH(DW), .H(4), .W(4), .F(3)) dut_s (
    .clk(clk), .reset(reset), .start(s_start), .abort(s_abort),
    .busy(s_busy), .done(s_done), .cu_start(s_cu_start),
    .cu_row(s_cu_row), .cu_col(s_cu_col), .cu_done(s_cu_done),
    .cu_result(s_cu_result), .out_we(s_out_we), .out_addr(s_out_addr),
    .out_data(s_out_data)
  );

  // default-parameter instance
  logic          d_start, d_abort, d_busy, d_done, d_cu_start, d_cu_done, d_out_we;
  logic [4:0]    d_cu_row, d_cu_col;
  logic [9:0]    d_out_addr;
  logic [DW-1:0] d_cu_result, d_out_data;

  conv_layer_sequencer dut_d (
    .clk(clk), .reset(reset), .start(d_start), .abort(d_abort),
    .busy(d_busy), .done(d_done), .cu_start(d_cu_start),
    .cu_row(d_cu_row), .cu_col(d_cu_col), .cu_done(d_cu_done),
    .cu_result(d_cu_result), .out_we(d_out_we), .out_addr(d_out_addr),
    .out_data(d_out_data)
  );

  // observed writes / done pulses, and the model's expected writes
  int            s_wr_addr[$];
  logic [DW-1:0] s_wr_data[$];
  int            s_exp_addr[$];
  logic [DW-1:0] s_exp_data[$];
  int            s_done_cnt = 0;
  int            d_wr_addr[$];
  logic [DW-1:0] d_wr_data[$];
  int            d_exp_addr[$];
  logic [DW-1:0] d_exp_data[$];
  int            d_done_cnt = 0;

  always @(negedge clk) begin
    if (s_out_we) begin
      s_wr_addr.push_back(int'(s_out_addr));
      s_wr_data.push_back(s_out_data);
    end else begin
      check_eq("s_idle_bus_zero", 64'({s_out_addr, s_out_data}), 64'd0);
    end
    if (s_done) s_done_cnt++;
    if (d_out_we) begin
      d_wr_addr.push_back(int'(d_out_addr));
      d_wr_data.push_back(d_out_data);
    end else begin
      check_eq("d_idle_bus_zero", 64'({d_out_addr, d_out_data}), 64'd0);
    end
    if (d_done) d_done_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic cmp_s(input string tag);
    check_eq({tag, "_nwr"}, s_wr_addr.size(), s_exp_addr.size());
    for (int i = 0; i < s_exp_addr.size() && i < s_wr_addr.size(); i++) begin
      check_eq({tag, "_addr"}, s_wr_addr[i], s_exp_addr[i]);
      check_eq({tag, "_data"}, s_wr_data[i], s_exp_data[i]);
    end
    s_wr_addr.delete(); s_wr_data.delete();
    s_exp_addr.delete(); s_exp_data.delete();
  endtask

  // lat_mode: 0 = every cu_done after 1 cycle, >0 = that latency on position 2,
  // <0 = random latency 1..4 everywhere. intr_kind 1 = abort in WAIT, 2 = reset in WRITE.
  task automatic run_s(input int lat_mode, input bit fixed, input bit noisy,
                       input int intr_pos, input int intr_kind, output int len);
    int k, t0, waitc, exp_len;
    logic [DW-1:0] v;
    len = 0; t0 = 0; exp_len = 1;
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    for (int p = 0; p < S_N; p++) begin
      waitc = 0;
      while (!s_cu_start && waitc < 8) begin @(negedge clk); waitc++; end
      check_eq("s_issue_seen", s_cu_start, 1);
      if (!s_cu_start) return;
      if (p == 0) t0 = cyc;
      check_eq("s_issue_row", s_cu_row, p / S_OW);
      check_eq("s_issue_col", s_cu_col, p % S_OW);
      if (lat_mode < 0) k = $urandom_range(1, 4);
      else if (lat_mode > 0 && p == 2) k = lat_mode;
      else k = 1;
      exp_len += 2 + k;
      if (noisy) begin s_cu_done = 1'b1; s_cu_result = 32'hdead_beef; end
      @(negedge clk);
      s_cu_done = 1'b0;
      for (int j = 1; j <= k; j++) begin
        check_eq("s_wait_row_hold", s_cu_row, p / S_OW);
        check_eq("s_wait_col_hold", s_cu_col, p % S_OW);
        check_eq("s_wait_busy", s_busy, 1);
        if (noisy && j == 1) s_start = 1'b1;
        if (intr_kind == 1 && p == intr_pos) begin
          s_abort = 1'b1; s_cu_done = 1'b1; s_cu_result = 32'h0bad_0bad;
          @(negedge clk);
          s_abort = 1'b0; s_cu_done = 1'b0;
          check_eq("abort_busy", s_busy, 0);
          check_eq("abort_cu_start", s_cu_start, 0);
          check_eq("abort_we", s_out_we, 0);
          return;
        end
        if (j == k) begin
          v = fixed ? DW'(32'h11 * (p + 1)) : DW'($urandom);
          s_cu_done = 1'b1;
          s_cu_result = v;
          s_exp_addr.push_back(p);
          s_exp_data.push_back(v);
        end
        @(negedge clk);
        s_start = 1'b0;
        s_cu_done = 1'b0;
        s_cu_result = DW'($urandom);
      end
      check_eq("s_write_we", s_out_we, 1);
      if (intr_kind == 2 && p == intr_pos) begin
        #2 reset = 1'b1;
        #1;
        check_eq("rst_we", s_out_we, 0);
        check_eq("rst_busy", s_busy, 0);
        check_eq("rst_cu_start", s_cu_start, 0);
        check_eq("rst_rowcol", {s_cu_row, s_cu_col}, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_idle_busy", s_busy, 0);
        check_eq("rst_idle_cu_start", s_cu_start, 0);
        return;
      end
      @(negedge clk);
    end
    check_eq("s_done_pulse", s_done, 1);
    len = cyc - t0 + 1;
    check_eq("s_pass_len", len, exp_len);
    @(negedge clk);
    check_eq("s_busy_after", s_busy, 0);
    check_eq("s_done_after", s_done, 0);
  endtask

  task automatic run_d();
    int k, t0, waitc, exp_len;
    logic [DW-1:0] v;
    t0 = 0; exp_len = 1;
    d_start = 1'b1;
    @(negedge clk);
    d_start = 1'b0;
    for (int p = 0; p < D_N; p++) begin
      waitc = 0;
      while (!d_cu_start && waitc < 8) begin @(negedge clk); waitc++; end
      check_eq("d_issue_seen", d_cu_start, 1);
      if (!d_cu_start) return;
      if (p == 0) t0 = cyc;
      check_eq("d_issue_row", d_cu_row, p / D_OW);
      check_eq("d_issue_col", d_cu_col, p % D_OW);
      k = $urandom_range(1, 2);
      exp_len += 2 + k;
      @(negedge clk);
      for (int j = 1; j <= k; j++) begin
        if (j == k) begin
          v = DW'($urandom);
          d_cu_done = 1'b1;
          d_cu_result = v;
          d_exp_addr.push_back(p);
          d_exp_data.push_back(v);
        end
        @(negedge clk);
        d_cu_done = 1'b0;
      end
      @(negedge clk);
    end
    check_eq("d_done_pulse", d_done, 1);
    check_eq("d_pass_len", cyc - t0 + 1, exp_len);
    @(negedge clk);
    check_eq("d_busy_after", d_busy, 0);
    check_eq("d_nwr", d_wr_addr.size(), D_N);
    for (int i = 0; i < d_exp_addr.size() && i < d_wr_addr.size(); i++) begin
      check_eq("d_addr", d_wr_addr[i], d_exp_addr[i]);
      check_eq("d_data", d_wr_data[i], d_exp_data[i]);
    end
    if (d_wr_addr.size() > 0) check_eq("d_last_addr", d_wr_addr[d_wr_addr.size() - 1], 783);
    check_eq("d_done_cnt", d_done_cnt, 1);
  endtask

  initial begin
    int len, dc0;
    reset = 1'b1;
    s_start = 1'b0; s_abort = 1'b0; s_cu_done = 1'b0; s_cu_result = '0;
    d_start = 1'b0; d_abort = 1'b0; d_cu_done = 1'b0; d_cu_result = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("reset_busy", s_busy, 0);
    check_eq("reset_done", s_done, 0);
    check_eq("reset_cu_start", s_cu_start, 0);
    check_eq("reset_rowcol", {s_cu_row, s_cu_col}, 0);
    check_eq("reset_out", 64'({s_out_we, s_out_addr, s_out_data}), 64'd0);

    // nominal
    dc0 = s_done_cnt;
    run_s(0, 1'b1, 1'b0, -1, 0, len);
    check_eq("nom_len", len, 13);
    check_eq("nom_done_cnt", s_done_cnt - dc0, 1);
    cmp_s("nom");

    // slow result on position 2
    run_s(5, 1'b0, 1'b0, -1, 0, len);
    check_eq("lat_len", len, 17);
    cmp_s("lat");

    // spurious cu_done in IDLE, then noisy pass
    s_cu_done = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check_eq("idle_cu_done_busy", s_busy, 0);
      check_eq("idle_cu_done_issue", s_cu_start, 0);
    end
    s_cu_done = 1'b0;
    dc0 = s_done_cnt;
    run_s(0, 1'b0, 1'b1, -1, 0, len);
    check_eq("noisy_done_cnt", s_done_cnt - dc0, 1);
    cmp_s("noisy");

    // start and abort together in IDLE
    s_start = 1'b1; s_abort = 1'b1;
    @(negedge clk);
    s_start = 1'b0; s_abort = 1'b0;
    check_eq("start_abort_idle", s_busy, 0);

    // abort in WAIT of position 1, then restart
    dc0 = s_done_cnt;
    run_s(0, 1'b0, 1'b0, 1, 1, len);
    repeat (4) @(negedge clk);
    check_eq("abort_no_done", s_done_cnt - dc0, 0);
    check_eq("abort_still_idle", s_busy, 0);
    cmp_s("abort");
    run_s(0, 1'b0, 1'b0, -1, 0, len);
    cmp_s("abort_restart");

    // async reset in WRITE of position 1, then full pass
    dc0 = s_done_cnt;
    run_s(0, 1'b0, 1'b0, 1, 2, len);
    check_eq("rst_no_done", s_done_cnt - dc0, 0);
    cmp_s("rst");
    run_s(0, 1'b0, 1'b0, -1, 0, len);
    cmp_s("rst_restart");

    // random latencies and data
    for (int n = 0; n < 6; n++) begin
      dc0 = s_done_cnt;
      run_s(-1, 1'b0, 1'b0, -1, 0, len);
      check_eq("rnd_done_cnt", s_done_cnt - dc0, 1);
      cmp_s("rnd");
    end

    run_d();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
